// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_shift_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_shift_core #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  start,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [DATA_W-1:0]     a_mag,
    input  logic [DATA_W-1:0]     b_mag,
    output logic [2*DATA_W-1:0]   acc,
    output logic                  last
);

    localparam int CNT_W = $clog2(DATA_W);

    // divisor also serves as the multiplicand in multiply mode
    logic [DATA_W-1:0]   divisor;
    logic [CNT_W-1:0]    cnt;
    logic                div_mode;
    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     sub_diff;
    logic [2*DATA_W-1:0] acc_next;

    always_comb begin
        add_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, divisor & {DATA_W{acc[0]}}};
        rem_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        sub_diff  = rem_shift - {1'b0, divisor};
        if (div_mode) begin
            // borrow out means the trial subtraction failed: restore and shift in 0
            if (sub_diff[DATA_W])
                acc_next = {rem_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
            else
                acc_next = {sub_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        end else begin
            acc_next = {add_sum, acc[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc      <= {{DATA_W{1'b0}}, a_mag};
            divisor  <= b_mag;
            cnt      <= '0;
            div_mode <= is_div;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit consuming ID/EX; stalls the front end while busy.
// Build option MULDIV_EARLY_OUT_EN: divide-by-zero and overflow divides skip the iteration phase.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int RF_ADDRESS_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Valid,
    input  logic                    Flush,
    input  logic [6:0]              opcode,
    input  logic [6:0]              Funct7,
    input  logic [2:0]              Funct3,
    input  logic [DATA_W-1:0]       Rs1Val,
    input  logic [DATA_W-1:0]       Rs2Val,
    input  logic [RF_ADDRESS_W-1:0] RD,
    output logic                    Stall,
    output logic                    Done,
    output logic [DATA_W-1:0]       Result,
    output logic [RF_ADDRESS_W-1:0] RD_Out
);

    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    function automatic logic [2*DATA_W-1:0] neg_wide(input logic [2*DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] neg_word(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t                  state;
    logic                    is_m;
    logic                    accept;
    logic                    early_out;
    logic                    a_signed;
    logic                    b_signed;
    logic                    sa;
    logic                    sb;
    logic                    in_div0;
    logic                    in_ovf;
    logic [DATA_W-1:0]       a_mag;
    logic [DATA_W-1:0]       b_mag;
    logic [2:0]              op_q;
    logic [RF_ADDRESS_W-1:0] rd_q;
    logic                    neg_q;
    logic                    div0_q;
    logic                    ovf_q;
    logic [DATA_W-1:0]       dividend_q;
    logic [2*DATA_W-1:0]     acc;
    logic                    core_last;
    logic [2*DATA_W-1:0]     prod;
    logic [DATA_W-1:0]       quot;
    logic [DATA_W-1:0]       remd;
    logic [DATA_W-1:0]       fix_value;

    assign is_m   = Valid && (opcode == OPCODE_OP) && (Funct7 == FUNCT7_MULDIV);
    assign accept = (state == ST_IDLE) && is_m && !Flush;

    assign a_signed = (Funct3 != F3_MULHU) && (Funct3 != F3_DIVU) && (Funct3 != F3_REMU);
    assign b_signed = (Funct3 == F3_MUL) || (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
    assign sa       = a_signed && Rs1Val[DATA_W-1];
    assign sb       = b_signed && Rs2Val[DATA_W-1];
    assign a_mag    = sa ? -Rs1Val : Rs1Val;
    assign b_mag    = sb ? -Rs2Val : Rs2Val;
    assign in_div0  = Funct3[2] && (Rs2Val == '0);
    assign in_ovf   = Funct3[2] && !Funct3[0] && (Rs1Val == MIN_NEG) && (Rs2Val == ALL_ONES);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = in_div0 || in_ovf;
`else
    assign early_out = 1'b0;
`endif

    muldiv_shift_core #(.DATA_W(DATA_W)) u_core (
        .clk    (clk),
        .start  (accept),
        .step   (state == ST_CALC),
        .is_div (Funct3[2]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc),
        .last   (core_last)
    );

    // Sign fix-up, word select and the RISC-V defined results for x/0 and MIN/-1
    always_comb begin
        prod      = neg_wide(acc, neg_q);
        quot      = neg_word(acc[DATA_W-1:0], neg_q);
        remd      = neg_word(acc[2*DATA_W-1:DATA_W], neg_q);
        fix_value = remd;
        case (op_q)
            F3_MUL:                       fix_value = prod[DATA_W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_value = prod[2*DATA_W-1:DATA_W];
            F3_DIV, F3_DIVU:              fix_value = quot;
            default:                      fix_value = remd;
        endcase
        if (op_q[2] && div0_q)
            fix_value = op_q[1] ? dividend_q : ALL_ONES;
        else if (op_q[2] && ovf_q)
            fix_value = op_q[1] ? '0 : MIN_NEG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            Result <= '0;
            RD_Out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= Funct3;
                        rd_q       <= RD;
                        neg_q      <= (Funct3[2] && Funct3[1]) ? sa : (sa ^ sb);
                        div0_q     <= in_div0;
                        ovf_q      <= in_ovf;
                        dividend_q <= Rs1Val;
                        state      <= early_out ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (Flush)          state <= ST_IDLE;
                    else if (core_last) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (Flush) begin
                        state <= ST_IDLE;
                    end else begin
                        Result <= fix_value;
                        RD_Out <= rd_q;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Stall = !reset && !Flush &&
                   (((state == ST_IDLE) && is_m) || (state == ST_CALC) || (state == ST_FIX));
    assign Done  = !reset && !Flush && (state == ST_DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases plus random ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Valid;
    logic        Flush;
    logic [6:0]  opcode;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic [31:0] Rs1Val;
    logic [31:0] Rs2Val;
    logic [4:0]  RD;
    logic        Stall;
    logic        Done;
    logic [31:0] Result;
    logic [4:0]  RD_Out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_result = 32'h0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    ex_muldiv_unit #(.DATA_W(32), .RF_ADDRESS_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .Valid  (Valid),
        .Flush  (Flush),
        .opcode (opcode),
        .Funct7 (Funct7),
        .Funct3 (Funct3),
        .Rs1Val (Rs1Val),
        .Rs2Val (Rs2Val),
        .RD     (RD),
        .Stall  (Stall),
        .Done   (Done),
        .Result (Result),
        .RD_Out (RD_Out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'h0, b});
        logic [63:0] p;
        bit          ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'(int'(a) / int'(b));
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(int'(a) % int'(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit special = f3[2] && ((b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        return (EARLY && special) ? 2 : 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        Valid  = 1'b1;
        Flush  = 1'b0;
        opcode = 7'b0110011;
        Funct7 = 7'b0000001;
        Funct3 = f3;
        Rs1Val = a;
        Rs2Val = b;
        RD     = rd;
    endtask

    // Presents one M instruction from the next cycle on and holds it until Done.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int          k      = 0;
        int          stalls = 0;
        bit          seen   = 1'b0;
        logic [31:0] exp    = ref_result(f3, a, b);
        int          lat    = exp_lat(f3, a, b);
        @(posedge clk); #1;
        drive_m(f3, a, b, rd);
        while (k < 100) begin
            @(negedge clk);
            if (k == 0) begin
                check({tag, "/done_at_accept"}, 32'(Done), 32'd0);
                check({tag, "/stall_at_accept"}, 32'(Stall), 32'd1);
            end
            if (Stall) stalls++;
            if (Done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        if (!seen) begin
            check({tag, "/timeout_done"}, 32'(Done), 32'd1);
        end else begin
            check({tag, "/done_cycle"}, 32'(k), 32'(lat));
            check({tag, "/stall_cycles"}, 32'(stalls), 32'(lat));
            check({tag, "/stall_in_done"}, 32'(Stall), 32'd0);
            check({tag, "/result"}, Result, exp);
            check({tag, "/rd_out"}, 32'(RD_Out), 32'(rd));
            last_result = exp;
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        Valid = 1'b0;
        Flush = 1'b0;
        @(negedge clk);
        check({tag, "/done_after"}, 32'(Done), 32'd0);
        check({tag, "/stall_after"}, 32'(Stall), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        Valid  = 1'b0;
        Flush  = 1'b0;
        opcode = 7'h0;
        Funct7 = 7'h0;
        Funct3 = 3'h0;
        Rs1Val = 32'h0;
        Rs2Val = 32'h0;
        RD     = 5'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/stall", 32'(Stall), 32'd0);
        check("reset/done", 32'(Done), 32'd0);
        check("reset/result", Result, 32'h0);
        check("reset/rd_out", 32'(RD_Out), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Non-M instruction and bubbles never stall
        Valid = 1'b1; opcode = 7'b0110011; Funct7 = 7'h0; Funct3 = 3'h0;
        Rs1Val = 32'd3; Rs2Val = 32'd4; RD = 5'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("add/stall", 32'(Stall), 32'd0);
            check("add/done", 32'(Done), 32'd0);
            @(posedge clk); #1;
        end
        drive_m(3'd0, 32'd3, 32'd4, 5'd9);
        Valid = 1'b0;
        @(negedge clk);
        check("bubble/stall", 32'(Stall), 32'd0);

        run_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);             idle_cycle("mul");
        run_op("mulh", 3'd1, 32'h80000000, 32'h80000000, 5'd6);     idle_cycle("mulh");
        run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);    idle_cycle("mulhu");
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);   idle_cycle("mulhsu");
        run_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd10);            idle_cycle("div");
        run_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd11);            idle_cycle("rem");
        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd12);                idle_cycle("divu");
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd13);                idle_cycle("remu");
        run_op("div0", 3'd4, 32'd5, 32'd0, 5'd14);                  idle_cycle("div0");
        run_op("remu0", 3'd7, 32'd5, 32'd0, 5'd15);                 idle_cycle("remu0");
        run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16);  idle_cycle("divovf");
        run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd17);  idle_cycle("removf");

        // Back-to-back: second op presented right after the first Done
        run_op("b2b_first", 3'd0, 32'd1234, 32'd5678, 5'd18);
        run_op("b2b_second", 3'd0, 32'hDEADBEEF, 32'd3, 5'd19);
        idle_cycle("b2b");

        // Flush in the 11th cycle of an op; the next op must be accepted at once
        @(posedge clk); #1;
        drive_m(3'd0, 32'd99, 32'd77, 5'd20);
        repeat (10) @(posedge clk);
        #1 Flush = 1'b1;
        @(negedge clk);
        check("flush/stall", 32'(Stall), 32'd0);
        check("flush/done", 32'(Done), 32'd0);
        check("flush/result_kept", Result, last_result);
        run_op("after_flush", 3'd5, 32'd1000, 32'd9, 5'd21);
        idle_cycle("after_flush");

        // Reset in the 6th cycle of an op
        @(posedge clk); #1;
        drive_m(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd22);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midreset/stall_during", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset/result", Result, 32'h0);
        check("midreset/rd_out", 32'(RD_Out), 32'h0);
        check("midreset/done", 32'(Done), 32'd0);
        check("midreset/stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        Valid = 1'b0;
        run_op("after_reset", 3'd6, 32'hFFFFFF00, 32'd7, 5'd23);
        idle_cycle("after_reset");

        for (int i = 0; i < 30; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick_operand(),
                   pick_operand(), 5'($urandom_range(0, 31)));
            idle_cycle($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
